fetch_stage: RTL and testbench

- LEGv8 instruction fetch stage. Holds the PC, issues single-outstanding requests to instruction memory, and loads the IF/ID pipeline register.
- It is the producing end of the decode interface: ifid_instr[31:21] drives the main decoder's Op input.
- It honours hazard-unit stalls and branch flush/redirect from the MEM stage.
- A flushed slot is loaded with an all-zero instruction, which the decoder maps to all-zero control signals.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/ifid_reg.sv | 47 ++++
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
package fetch_pkg;

  // FETCH issues a request, WAIT expects the response, HOLD parks a response
  // captured during a stall, DROP swallows a response squashed by a flush.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  // The decoder maps an all-zero word to all-zero control signals.
  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Sequential PC step.
  localparam int PC_INCR = 4;

  // PC value after reset.
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: clear beats hold beats load; otherwise a bubble.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int N  = 64,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          hold,
  input  logic          clear,
  input  logic [N-1:0]  load_pc,
  input  logic [IW-1:0] load_instr,
  output logic          valid,
  output logic [N-1:0]  pc,
  output logic [IW-1:0] instr
);

  // Pipeline register update with flush > stall > load > bubble priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= IW'(NOP_INSTR);
    end else if (clear) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      valid <= 1'b0;
      pc    <= '0;
      instr <= IW'(NOP_INSTR);
    end else if (hold) begin
      valid <= valid;
      pc    <= pc;
      instr <= instr;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else begin
      // Nothing new arrived: insert a bubble; pc is left as is.
      valid <= 1'b0;
      instr <= IW'(NOP_INSTR);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: owns the PC, keeps one instruction-memory request in
// flight, and feeds the IF/ID register honouring stall and branch flush.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          N        = 64,
  parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC),
  parameter int          IW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic [N-1:0]  branch_target,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_ready,
  input  logic [IW-1:0] imem_rdata,
  output logic          ifid_valid,
  output logic [N-1:0]  ifid_pc,
  output logic [IW-1:0] ifid_instr
);

  state_t        state;
  logic [N-1:0]  pc;
  logic          hold_valid;
  logic [IW-1:0] hold_instr;

  logic          load_direct;
  logic          load_held;
  logic          ifid_load;
  logic [IW-1:0] ifid_load_instr;

  // Request strobe is combinational so the address goes out in the FETCH
  // cycle itself; it is gated by reset and suppressed by a redirect.
  assign imem_req  = reset && (state == FETCH) && !flush;
  assign imem_addr = pc;

  // IF/ID is loaded straight from memory or from the hold buffer after a stall.
  assign load_direct     = (state == WAIT) && imem_ready && !stall;
  assign load_held       = (state == HOLD) && hold_valid && !stall;
  assign ifid_load       = !flush && (load_direct || load_held);
  assign ifid_load_instr = (state == HOLD) ? hold_instr : imem_rdata;

  // Fetch control FSM: PC, state and hold-buffer occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      hold_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (flush) pc <= branch_target;
          else       state <= WAIT;
        end
        WAIT: begin
          if (flush) begin
            pc    <= branch_target;
            state <= imem_ready ? FETCH : DROP;
          end else if (imem_ready) begin
            if (stall) begin
              hold_valid <= 1'b1;
              state      <= HOLD;
            end else begin
              pc    <= pc + N'(PC_INCR);
              state <= FETCH;
            end
          end
        end
        HOLD: begin
          if (flush) begin
            hold_valid <= 1'b0;
            pc         <= branch_target;
            state      <= FETCH;
          end else if (!stall) begin
            hold_valid <= 1'b0;
            pc         <= pc + N'(PC_INCR);
            state      <= FETCH;
          end
        end
        DROP: begin
          if (flush)      pc <= branch_target;
          if (imem_ready) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Hold buffer data, written when a response lands during a stall.
  always_ff @(posedge clk) begin
    // NOTE: pure data storage needs no reset; hold_valid qualifies its content.
    if (state == WAIT && imem_ready && stall && !flush) hold_instr <= imem_rdata;
  end

  ifid_reg #(
    .N  (N),
    .IW (IW)
  ) u_ifid_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (ifid_load),
    .hold       (stall),
    .clear      (flush),
    .load_pc    (pc),
    .load_instr (ifid_load_instr),
    .valid      (ifid_valid),
    .pc         (ifid_pc),
    .instr      (ifid_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage. Inputs change on the falling
// edge; outputs are compared 1 time unit later, ahead of the next rising edge.
module tb_fetch_stage;

  localparam logic [31:0] ADD  = 32'h8B02_0020;
  localparam logic [31:0] LDUR = 32'hF840_0041;
  localparam int NV = 21;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [63:0] branch_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        ready;
    logic [31:0] rdata;
    logic [63:0] bt;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic        chk_pc;
    logic [63:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t tbl [NV];

  fetch_stage #(
    .N        (64),
    .RESET_PC (64'h0),
    .IW       (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .ifid_valid    (ifid_valid),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs, then move to the next falling edge.
  task automatic apply(input string tag, input vec_t v);
    stall         = v.stall;
    flush         = v.flush;
    imem_ready    = v.ready;
    imem_rdata    = v.rdata;
    branch_target = v.bt;
    #1;
    check({tag, " imem_req"}, 64'(imem_req), 64'(v.exp_req));
    if (v.exp_req) check({tag, " imem_addr"}, imem_addr, v.exp_addr);
    check({tag, " ifid_valid"}, 64'(ifid_valid), 64'(v.exp_valid));
    check({tag, " ifid_instr"}, 64'(ifid_instr), 64'(v.exp_instr));
    if (v.chk_pc) check({tag, " ifid_pc"}, ifid_pc, v.exp_pc);
    @(negedge clk);
  endtask

  initial begin
    // stall flush ready rdata bt | req addr | valid chk_pc pc instr
    // Basic fetch, then a 3-cycle stall with a response parked in HOLD.
    tbl[0]  = '{0, 0, 0, 32'h0, 64'h0,   1, 64'h0,   0, 1, 64'h0,   32'h0};
    tbl[1]  = '{0, 0, 1, ADD,   64'h0,   0, 64'h0,   0, 1, 64'h0,   32'h0};
    tbl[2]  = '{1, 0, 0, 32'h0, 64'h0,   1, 64'h4,   1, 1, 64'h0,   ADD};
    tbl[3]  = '{1, 0, 1, LDUR,  64'h0,   0, 64'h0,   1, 1, 64'h0,   ADD};
    tbl[4]  = '{1, 0, 0, 32'h0, 64'h0,   0, 64'h0,   1, 1, 64'h0,   ADD};
    tbl[5]  = '{0, 0, 0, 32'h0, 64'h0,   0, 64'h0,   1, 1, 64'h0,   ADD};
    tbl[6]  = '{0, 0, 0, 32'h0, 64'h0,   1, 64'h8,   1, 1, 64'h4,   LDUR};
    // Flush in WAIT with a late response that must be dropped.
    tbl[7]  = '{0, 1, 0, 32'h0, 64'h100, 0, 64'h0,   0, 0, 64'h0,   32'h0};
    tbl[8]  = '{0, 0, 0, 32'h0, 64'h0,   0, 64'h0,   0, 1, 64'h0,   32'h0};
    tbl[9]  = '{0, 0, 1, ADD,   64'h0,   0, 64'h0,   0, 0, 64'h0,   32'h0};
    tbl[10] = '{0, 0, 0, 32'h0, 64'h0,   1, 64'h100, 0, 0, 64'h0,   32'h0};
    // Flush and stall together while IF/ID holds a real instruction.
    tbl[11] = '{0, 0, 1, LDUR,  64'h0,   0, 64'h0,   0, 0, 64'h0,   32'h0};
    tbl[12] = '{1, 1, 0, 32'h0, 64'h200, 0, 64'h0,   1, 1, 64'h100, LDUR};
    tbl[13] = '{0, 0, 0, 32'h0, 64'h0,   1, 64'h200, 0, 1, 64'h0,   32'h0};
    // Flush coinciding with a response, then flush out of HOLD.
    tbl[14] = '{0, 1, 1, ADD,   64'h300, 0, 64'h0,   0, 0, 64'h0,   32'h0};
    tbl[15] = '{0, 0, 0, 32'h0, 64'h0,   1, 64'h300, 0, 0, 64'h0,   32'h0};
    tbl[16] = '{1, 0, 1, ADD,   64'h0,   0, 64'h0,   0, 0, 64'h0,   32'h0};
    tbl[17] = '{1, 1, 0, 32'h0, 64'h400, 0, 64'h0,   0, 0, 64'h0,   32'h0};
    tbl[18] = '{0, 0, 0, 32'h0, 64'h0,   1, 64'h400, 0, 1, 64'h0,   32'h0};
    tbl[19] = '{0, 0, 1, LDUR,  64'h0,   0, 64'h0,   0, 0, 64'h0,   32'h0};
    tbl[20] = '{0, 0, 0, 32'h0, 64'h0,   1, 64'h404, 1, 1, 64'h400, LDUR};

    reset = 1'b0; stall = 1'b0; flush = 1'b0; branch_target = '0;
    imem_ready = 1'b0; imem_rdata = '0;

    // Outputs during the initial reset.
    @(negedge clk);
    #1;
    check("reset imem_req",   64'(imem_req),   64'h0);
    check("reset ifid_valid", 64'(ifid_valid), 64'h0);
    check("reset ifid_pc",    ifid_pc,         64'h0);
    check("reset ifid_instr", 64'(ifid_instr), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // PC wrap: redirect to the last word, then fetch past it.
    apply("wrap0", '{0, 1, 0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0, 0, 64'h0, 32'h0});
    apply("wrap1", '{0, 0, 1, LDUR,  64'h0, 0, 64'h0, 0, 1, 64'h0, 32'h0});
    apply("wrap2", '{0, 0, 0, 32'h0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0, 32'h0});
    apply("wrap3", '{0, 0, 1, ADD,   64'h0, 0, 64'h0, 0, 0, 64'h0, 32'h0});
    stall = 1'b0; flush = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    #1;
    check("wrap4 decoder op", 64'(ifid_instr[31:21]), 64'(11'b10001011000));
    apply("wrap4", '{0, 0, 0, 32'h0, 64'h0, 1, 64'h0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, ADD});

    // Reset while a request is outstanding in WAIT.
    reset = 1'b0;
    #1;
    check("midrst imem_req",   64'(imem_req),   64'h0);
    check("midrst imem_addr",  imem_addr,       64'h0);
    check("midrst ifid_valid", 64'(ifid_valid), 64'h0);
    check("midrst ifid_pc",    ifid_pc,         64'h0);
    check("midrst ifid_instr", 64'(ifid_instr), 64'h0);
    @(negedge clk);
    #1;
    check("midrst held imem_req", 64'(imem_req), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    // The stray response shows up in the first post-reset cycle.
    apply("postrst0", '{0, 0, 1, ADD,  64'h0, 1, 64'h0, 0, 1, 64'h0, 32'h0});
    apply("postrst1", '{0, 0, 1, LDUR, 64'h0, 0, 64'h0, 0, 1, 64'h0, 32'h0});
    apply("postrst2", '{0, 0, 0, 32'h0, 64'h0, 1, 64'h4, 1, 1, 64'h0, LDUR});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
